// File: rtl/mem_align_unit.sv
// -----------------------------------------------------------------------------
// mem_align_unit
//
// MEM-stage front end for DataCache. Aligned loads/stores go straight through
// to the cache in one cycle. A misaligned load is split into two word reads;
// the two words are merged and sign/zero-extended here. A misaligned store is
// split into one byte write per byte, stalling the pipeline until the last
// byte issues. With EXC_ON_MISALIGN=1 a misaligned request is not split:
// io_misaligned is raised and the cache is left untouched.
//
// Request handshake: io_req_valid qualifies the io_req_* fields. io_stall is
// the not-ready indication. While io_stall=1 the upstream stage must hold
// every io_req_* field stable. A request completes in the cycle where
// io_resp_valid=1 (load data on io_resp_data, or store fully issued).
// Dropping io_req_valid while a split is in flight flushes it.
//
// Ports:
//   clock, reset            core clock, asynchronous active-low reset
//   io_req_*                MEM-stage request (addr, wdata, read, write,
//                           size, unsigned)
//   io_stall                hold EX/MEM and upstream stages
//   io_resp_valid/data      completion strobe and extended load result
//   io_misaligned           misaligned exception (EXC_ON_MISALIGN=1 only)
//   io_cache_*              DataCache interface (combinational read,
//                           write commits on the rising clock edge)
//   dbg_state               current FSM state (0=IDLE, 1=LD_HI, 2=ST_BYTE)
// -----------------------------------------------------------------------------
module mem_align_unit #(
    parameter int XLEN            = 32,
    parameter bit EXC_ON_MISALIGN = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_req_valid,
    input  logic [XLEN-1:0] io_req_addr,
    input  logic [XLEN-1:0] io_req_wdata,
    input  logic            io_req_read,
    input  logic            io_req_write,
    input  logic [1:0]      io_req_size,
    input  logic            io_req_unsigned,
    output logic            io_stall,
    output logic            io_resp_valid,
    output logic [XLEN-1:0] io_resp_data,
    output logic            io_misaligned,
    output logic [XLEN-1:0] io_cache_addr,
    output logic [XLEN-1:0] io_cache_write_data,
    output logic            io_cache_Mem_Read,
    output logic            io_cache_Mem_Write,
    output logic [1:0]      io_cache_Data_Size,
    output logic            io_cache_Load_Type,
    input  logic [XLEN-1:0] io_cache_data_out,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_HI   = 2'd1,
        ST_BYTE = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      cnt;
    logic [XLEN-1:0] lo_word;

    logic            is_read;
    logic            is_write;
    logic [1:0]      size_eff;
    logic [1:0]      last_k;
    logic            misaligned;
    logic            split_req;
    logic [XLEN-1:0] word_base;
    logic [1:0]      byte_k;
    logic [7:0]      wbyte;
    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] ld_result;

    // Write wins when both read and write are requested.
    assign is_write = io_req_write;
    assign is_read  = io_req_read & ~io_req_write;

    // Size code 3 is illegal and behaves as a word access.
    assign size_eff = (io_req_size == 2'd3) ? 2'd2 : io_req_size;

    // Index of the final byte of a split store (N-1).
    assign last_k = (size_eff == 2'd2) ? 2'd3 :
                    (size_eff == 2'd1) ? 2'd1 : 2'd0;

    assign misaligned = ((size_eff == 2'd1) && io_req_addr[0]) ||
                        ((size_eff == 2'd2) && (io_req_addr[1:0] != 2'b00));

    assign split_req = io_req_valid && (is_read || is_write) && misaligned;

    assign word_base = {io_req_addr[XLEN-1:2], 2'b00};

    // The first byte of a split store is written from IDLE, so k is 0 there.
    assign byte_k = (state == ST_BYTE) ? cnt : 2'd0;
    assign wbyte  = io_req_wdata[{byte_k, 3'b000} +: 8];

    // {hi_word, lo_word} >> 8*addr[1:0], keeping the low word.
    always_comb begin
        merged = lo_word;
        unique case (io_req_addr[1:0])
            2'd0: merged = lo_word;
            2'd1: merged = {io_cache_data_out[7:0],  lo_word[31:8]};
            2'd2: merged = {io_cache_data_out[15:0], lo_word[31:16]};
            2'd3: merged = {io_cache_data_out[23:0], lo_word[31:24]};
        endcase
    end

    // Only half and word loads can be split, so only those extensions apply.
    always_comb begin
        ld_result = merged;
        if (size_eff == 2'd1) begin
            ld_result = io_req_unsigned ? {16'h0000, merged[15:0]}
                                        : {{16{merged[15]}}, merged[15:0]};
        end
    end

    // Output decode. Everything is forced to 0 while reset is asserted.
    always_comb begin
        io_stall            = 1'b0;
        io_resp_valid       = 1'b0;
        io_resp_data        = '0;
        io_misaligned       = 1'b0;
        io_cache_addr       = '0;
        io_cache_write_data = '0;
        io_cache_Mem_Read   = 1'b0;
        io_cache_Mem_Write  = 1'b0;
        io_cache_Data_Size  = 2'd0;
        io_cache_Load_Type  = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (split_req) begin
                        if (EXC_ON_MISALIGN) begin
                            io_misaligned = 1'b1;
                        end else if (is_read) begin
                            io_cache_addr      = word_base;
                            io_cache_Data_Size = 2'd2;
                            io_cache_Load_Type = io_req_unsigned;
                            io_cache_Mem_Read  = 1'b1;
                            io_stall           = 1'b1;
                        end else begin
                            io_cache_addr       = io_req_addr;
                            io_cache_Data_Size  = 2'd0;
                            io_cache_write_data = {24'h000000, wbyte};
                            io_cache_Mem_Write  = 1'b1;
                            io_stall            = 1'b1;
                        end
                    end else if (io_req_valid) begin
                        io_cache_addr       = io_req_addr;
                        io_cache_write_data = io_req_wdata;
                        io_cache_Data_Size  = io_req_size;
                        io_cache_Load_Type  = io_req_unsigned;
                        io_cache_Mem_Read   = is_read;
                        io_cache_Mem_Write  = is_write;
                        io_resp_valid       = is_read || is_write;
                        io_resp_data        = io_cache_data_out;
                    end
                end
                LD_HI: begin
                    if (io_req_valid) begin
                        // Wraps modulo 2^32 at the top of the address space.
                        io_cache_addr      = word_base + 32'd4;
                        io_cache_Data_Size = 2'd2;
                        io_cache_Load_Type = io_req_unsigned;
                        io_cache_Mem_Read  = 1'b1;
                        io_resp_valid      = 1'b1;
                        io_resp_data       = ld_result;
                    end
                end
                ST_BYTE: begin
                    if (io_req_valid) begin
                        io_cache_addr       = io_req_addr + {30'd0, cnt};
                        io_cache_Data_Size  = 2'd0;
                        io_cache_write_data = {24'h000000, wbyte};
                        io_cache_Mem_Write  = 1'b1;
                        io_stall            = (cnt != last_k);
                        io_resp_valid       = (cnt == last_k);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            lo_word <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (split_req && !EXC_ON_MISALIGN) begin
                        if (is_read) begin
                            lo_word <= io_cache_data_out;
                            state   <= LD_HI;
                        end else begin
                            // Byte 0 was written this cycle; continue at byte 1.
                            cnt   <= 2'd1;
                            state <= ST_BYTE;
                        end
                    end
                end
                LD_HI: begin
                    // Either the merge completed or the request was flushed.
                    state <= IDLE;
                end
                ST_BYTE: begin
                    if (!io_req_valid || (cnt == last_k)) begin
                        cnt   <= 2'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: begin
                    cnt   <= 2'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_align_unit.sv
`timescale 1ns/1ps
module tb_mem_align_unit;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- main DUT signals ----------------
    logic        io_req_valid = 1'b0;
    logic [31:0] io_req_addr = '0;
    logic [31:0] io_req_wdata = '0;
    logic        io_req_read = 1'b0;
    logic        io_req_write = 1'b0;
    logic [1:0]  io_req_size = 2'd0;
    logic        io_req_unsigned = 1'b0;
    logic        io_stall;
    logic        io_resp_valid;
    logic [31:0] io_resp_data;
    logic        io_misaligned;
    logic [31:0] io_cache_addr;
    logic [31:0] io_cache_write_data;
    logic        io_cache_Mem_Read;
    logic        io_cache_Mem_Write;
    logic [1:0]  io_cache_Data_Size;
    logic        io_cache_Load_Type;
    logic [31:0] io_cache_data_out;
    logic [1:0]  dbg_state;

    // ---------------- exception-mode DUT signals ----------------
    logic        x_valid = 1'b0;
    logic [31:0] x_addr = '0;
    logic [31:0] x_wdata = '0;
    logic        x_read = 1'b0;
    logic        x_write = 1'b0;
    logic [1:0]  x_size = 2'd0;
    logic        x_uns = 1'b0;
    logic        x_stall;
    logic        x_resp_valid;
    logic [31:0] x_resp_data;
    logic        x_mis;
    logic [31:0] x_cache_addr;
    logic [31:0] x_cache_wdata;
    logic        x_mem_read;
    logic        x_mem_write;
    logic [1:0]  x_data_size;
    logic        x_load_type;
    logic [31:0] x_cache_data = '0;
    logic [1:0]  x_dbg;

    mem_align_unit #(.XLEN(32), .EXC_ON_MISALIGN(1'b0)) u_dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_addr(io_req_addr),
        .io_req_wdata(io_req_wdata), .io_req_read(io_req_read),
        .io_req_write(io_req_write), .io_req_size(io_req_size),
        .io_req_unsigned(io_req_unsigned),
        .io_stall(io_stall), .io_resp_valid(io_resp_valid),
        .io_resp_data(io_resp_data), .io_misaligned(io_misaligned),
        .io_cache_addr(io_cache_addr), .io_cache_write_data(io_cache_write_data),
        .io_cache_Mem_Read(io_cache_Mem_Read), .io_cache_Mem_Write(io_cache_Mem_Write),
        .io_cache_Data_Size(io_cache_Data_Size), .io_cache_Load_Type(io_cache_Load_Type),
        .io_cache_data_out(io_cache_data_out), .dbg_state(dbg_state)
    );

    mem_align_unit #(.XLEN(32), .EXC_ON_MISALIGN(1'b1)) u_exc (
        .clock(clock), .reset(reset),
        .io_req_valid(x_valid), .io_req_addr(x_addr),
        .io_req_wdata(x_wdata), .io_req_read(x_read),
        .io_req_write(x_write), .io_req_size(x_size),
        .io_req_unsigned(x_uns),
        .io_stall(x_stall), .io_resp_valid(x_resp_valid),
        .io_resp_data(x_resp_data), .io_misaligned(x_mis),
        .io_cache_addr(x_cache_addr), .io_cache_write_data(x_cache_wdata),
        .io_cache_Mem_Read(x_mem_read), .io_cache_Mem_Write(x_mem_write),
        .io_cache_Data_Size(x_data_size), .io_cache_Load_Type(x_load_type),
        .io_cache_data_out(x_cache_data), .dbg_state(x_dbg)
    );

    // ---------------- DataCache model (4 KiB, address bits [11:0]) ----------------
    logic [7:0]  mem [0:4095];
    logic [11:0] ra;
    logic [31:0] rword;

    always_comb begin
        ra    = io_cache_addr[11:0];
        rword = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};
        case (io_cache_Data_Size)
            2'd0:    io_cache_data_out = io_cache_Load_Type ? {24'h0, rword[7:0]}
                                                            : {{24{rword[7]}}, rword[7:0]};
            2'd1:    io_cache_data_out = io_cache_Load_Type ? {16'h0, rword[15:0]}
                                                            : {{16{rword[15]}}, rword[15:0]};
            default: io_cache_data_out = rword;
        endcase
    end

    // Preload, then commit writes on each rising edge using values sampled
    // on the preceding falling edge.
    initial begin
        logic        pw_en;
        logic [11:0] pw_a;
        logic [1:0]  pw_sz;
        logic [31:0] pw_d;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
        mem[12'h104] = 8'h95; mem[12'h105] = 8'h66; mem[12'h106] = 8'h77; mem[12'h107] = 8'h88;
        mem[12'hFFC] = 8'h0D; mem[12'hFFD] = 8'hF0; mem[12'hFFE] = 8'hFE; mem[12'hFFF] = 8'hCA;
        mem[12'h000] = 8'h78; mem[12'h001] = 8'h56; mem[12'h002] = 8'h34; mem[12'h003] = 8'h12;
        forever begin
            @(negedge clock);
            pw_en = reset && io_cache_Mem_Write;
            pw_a  = io_cache_addr[11:0];
            pw_sz = io_cache_Data_Size;
            pw_d  = io_cache_write_data;
            @(posedge clock);
            if (pw_en && reset) begin
                mem[pw_a] = pw_d[7:0];
                if (pw_sz != 2'd0) mem[pw_a + 12'd1] = pw_d[15:8];
                if (pw_sz[1]) begin
                    mem[pw_a + 12'd2] = pw_d[23:16];
                    mem[pw_a + 12'd3] = pw_d[31:24];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];     // {check_data, data}
    logic [31:0] exp_rd_q[$];  // read addresses
    logic [65:0] exp_wr_q[$];  // {addr, size, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    logic [32:0] m_e;
    logic [31:0] m_r;
    logic [65:0] m_w;
    logic [31:0] m_mask;

    always @(negedge clock) begin
        if (io_resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL resp_unexpected actual=%h required=none at %0t", io_resp_data, $time);
            end else begin
                m_e = exp_q.pop_front();
                if (m_e[32]) check("resp_data", io_resp_data, m_e[31:0]);
            end
        end
        if (io_cache_Mem_Read) begin
            if (exp_rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_unexpected actual=%h required=none at %0t", io_cache_addr, $time);
            end else begin
                m_r = exp_rd_q.pop_front();
                check("rd_addr", io_cache_addr, m_r);
            end
        end
        if (io_cache_Mem_Write) begin
            if (exp_wr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr_unexpected actual=%h required=none at %0t", io_cache_addr, $time);
            end else begin
                m_w = exp_wr_q.pop_front();
                m_mask = (m_w[33:32] == 2'd0) ? 32'h000000FF :
                         (m_w[33:32] == 2'd1) ? 32'h0000FFFF : 32'hFFFFFFFF;
                check("wr_addr", io_cache_addr, m_w[65:34]);
                check("wr_size", {30'd0, io_cache_Data_Size}, {30'd0, m_w[33:32]});
                check("wr_data", io_cache_write_data & m_mask, m_w[31:0] & m_mask);
            end
        end
    end

    // ---------------- driver ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input vec_t v);
        int   cyc;
        int   n;
        logic [1:0] sz;
        logic mis;
        @(posedge clock); #1;
        io_req_valid = 1'b1; io_req_addr = v.addr; io_req_wdata = v.wdata;
        io_req_read = v.rd; io_req_write = v.wr; io_req_size = v.size;
        io_req_unsigned = v.uns;
        sz  = (v.size == 2'd3) ? 2'd2 : v.size;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis = ((sz == 2'd1) && v.addr[0]) || ((sz == 2'd2) && (v.addr[1:0] != 2'b00));
        if (v.wr) begin
            if (mis) begin
                for (int k = 0; k < n; k++)
                    exp_wr_q.push_back({v.addr + 32'(k), 2'd0, 24'h0, v.wdata[8*k +: 8]});
            end else begin
                exp_wr_q.push_back({v.addr, v.size, v.wdata});
            end
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            if (mis) begin
                exp_rd_q.push_back({v.addr[31:2], 2'b00});
                exp_rd_q.push_back({v.addr[31:2], 2'b00} + 32'd4);
            end else begin
                exp_rd_q.push_back(v.addr);
            end
            exp_q.push_back({1'b1, v.exp});
        end
        cyc = 0;
        while (1) begin
            @(negedge clock);
            cyc++;
            if (!io_stall) break;
            if (cyc >= 8) break;
        end
        check("latency", 32'(cyc), 32'(v.lat));
    endtask

    task automatic idle_req();
        @(posedge clock); #1;
        io_req_valid = 1'b0; io_req_read = 1'b0; io_req_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state, with a request already presented ----
        io_req_valid = 1'b1; io_req_read = 1'b1; io_req_addr = 32'h100; io_req_size = 2'd2;
        #2 reset = 1'b0;
        #10;
        check("rst_stall",     {31'd0, io_stall}, 32'd0);
        check("rst_resp_vld",  {31'd0, io_resp_valid}, 32'd0);
        check("rst_mem_read",  {31'd0, io_cache_Mem_Read}, 32'd0);
        check("rst_mem_write", {31'd0, io_cache_Mem_Write}, 32'd0);
        check("rst_resp_data", io_resp_data, 32'h0);
        check("rst_cache_addr", io_cache_addr, 32'h0);
        check("rst_state",     {30'd0, dbg_state}, 32'd0);
        io_req_valid = 1'b0; io_req_read = 1'b0;
        @(posedge clock); #1 reset = 1'b1;

        // ---- idle with no request ----
        @(negedge clock);
        check("idle_mem_read",  {31'd0, io_cache_Mem_Read}, 32'd0);
        check("idle_resp_vld",  {31'd0, io_resp_valid}, 32'd0);
        check("idle_stall",     {31'd0, io_stall}, 32'd0);

        // ---- vector table ----
        //              addr          wdata         rd    wr    size  uns   exp           lat
        vecs.push_back('{32'h00000100, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h44332211, 1});
        vecs.push_back('{32'h00000102, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h66954433, 2});
        vecs.push_back('{32'h00000103, 32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFF9544, 2});
        vecs.push_back('{32'h00000103, 32'h0,        1'b1, 1'b0, 2'd1, 1'b1, 32'h00009544, 2});
        vecs.push_back('{32'h00000104, 32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 32'hFFFFFF95, 1});
        vecs.push_back('{32'h00000104, 32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 32'h00000095, 1});
        vecs.push_back('{32'h00000102, 32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 32'h00004433, 1});
        vecs.push_back('{32'h00000101, 32'h0,        1'b1, 1'b0, 2'd1, 1'b1, 32'h00003322, 2});
        vecs.push_back('{32'hFFFFFFFE, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h5678CAFE, 2});
        vecs.push_back('{32'h000000FE, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0,        4});
        vecs.push_back('{32'h00000100, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h4433DEAD, 1});
        vecs.push_back('{32'h00000105, 32'h0000A5B6, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,        2});
        vecs.push_back('{32'h00000104, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h88A5B695, 1});
        vecs.push_back('{32'h00000108, 32'h01020304, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        1});
        vecs.push_back('{32'h00000107, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h02030488, 2});
        vecs.push_back('{32'h0000010B, 32'h0000007F, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        1});
        vecs.push_back('{32'h00000108, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h7F020304, 1});
        vecs.push_back('{32'h00000101, 32'h0,        1'b1, 1'b0, 2'd3, 1'b0, 32'h954433DE, 2});
        vecs.push_back('{32'hFFFFFFFF, 32'h0000ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,        2});
        vecs.push_back('{32'h00000000, 32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h123456AB, 1});
        foreach (vecs[i]) apply(vecs[i]);
        idle_req();

        // ---- reset asserted while in LD_HI ----
        @(posedge clock); #1;
        io_req_valid = 1'b1; io_req_addr = 32'h102; io_req_read = 1'b1;
        io_req_write = 1'b0; io_req_size = 2'd2; io_req_unsigned = 1'b0;
        exp_rd_q.push_back(32'h100);
        @(negedge clock);
        check("ldhi_stall_first", {31'd0, io_stall}, 32'd1);
        @(posedge clock); #1;
        check("ldhi_state", {30'd0, dbg_state}, 32'd1);
        reset = 1'b0;
        #1;
        check("ldhi_rst_stall", {31'd0, io_stall}, 32'd0);
        check("ldhi_rst_resp",  {31'd0, io_resp_valid}, 32'd0);
        check("ldhi_rst_state", {30'd0, dbg_state}, 32'd0);
        io_req_valid = 1'b0; io_req_read = 1'b0;
        @(posedge clock); #1 reset = 1'b1;

        // ---- flush during a split store ----
        @(posedge clock); #1;
        io_req_valid = 1'b1; io_req_addr = 32'h201; io_req_wdata = 32'h11223344;
        io_req_read = 1'b0; io_req_write = 1'b1; io_req_size = 2'd2;
        exp_wr_q.push_back({32'h201, 2'd0, 32'h00000044});
        @(negedge clock);
        check("flush_stall_first", {31'd0, io_stall}, 32'd1);
        @(posedge clock); #1;
        check("flush_state_st", {30'd0, dbg_state}, 32'd2);
        io_req_valid = 1'b0;
        @(negedge clock);
        check("flush_stall", {31'd0, io_stall}, 32'd0);
        check("flush_resp",  {31'd0, io_resp_valid}, 32'd0);
        check("flush_write", {31'd0, io_cache_Mem_Write}, 32'd0);
        @(posedge clock); #1;
        check("flush_state_idle", {30'd0, dbg_state}, 32'd0);
        io_req_write = 1'b0;
        apply('{32'h00000200, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h00004400, 1});
        idle_req();

        // ---- exception-on-misalign instance ----
        @(posedge clock); #1;
        x_valid = 1'b1; x_addr = 32'h101; x_read = 1'b1; x_size = 2'd1;
        @(negedge clock);
        check("exc_mis",       {31'd0, x_mis}, 32'd1);
        check("exc_mem_read",  {31'd0, x_mem_read}, 32'd0);
        check("exc_stall",     {31'd0, x_stall}, 32'd0);
        check("exc_resp",      {31'd0, x_resp_valid}, 32'd0);
        @(posedge clock); #1;
        check("exc_state", {30'd0, x_dbg}, 32'd0);
        x_valid = 1'b0;
        @(negedge clock);
        check("exc_mis_clear", {31'd0, x_mis}, 32'd0);
        @(posedge clock); #1;
        x_valid = 1'b1; x_addr = 32'h102; x_read = 1'b0; x_write = 1'b1; x_size = 2'd2;
        @(negedge clock);
        check("exc_st_mis",   {31'd0, x_mis}, 32'd1);
        check("exc_st_write", {31'd0, x_mem_write}, 32'd0);
        @(posedge clock); #1;
        x_addr = 32'h100; x_read = 1'b1; x_write = 1'b0; x_size = 2'd2;
        x_cache_data = 32'h5A5A1234;
        @(negedge clock);
        check("exc_al_mis",  {31'd0, x_mis}, 32'd0);
        check("exc_al_read", {31'd0, x_mem_read}, 32'd1);
        check("exc_al_data", x_resp_data, 32'h5A5A1234);
        @(posedge clock); #1 x_valid = 1'b0;

        // ---- drain ----
        repeat (3) @(posedge clock);
        check("resp_q_empty", 32'(exp_q.size()), 32'd0);
        check("rd_q_empty",   32'(exp_rd_q.size()), 32'd0);
        check("wr_q_empty",   32'(exp_wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- MEM-stage front end that sits directly upstream of DataCache and drives every DataCache input port.
- Aligned loads and stores pass through to the cache in a single cycle with no stall.
- A misaligned load is split into two word-aligned word reads. The result is merged, then sign- or zero-extended here.
- A misaligned store is split into sequential byte writes. The pipeline is stalled until the last piece issues.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- EXC_ON_MISALIGN, 0, when 1 a misaligned request is not split: io_misaligned asserts, no cache access is made, io_stall stays 0.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- io_req_valid  in  1  MEM-stage request present
- io_req_addr  in  32  byte address
- io_req_wdata  in  32  store data, bytes right-aligned
- io_req_read  in  1  load
- io_req_write  in  1  store
- io_req_size  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
- io_req_unsigned  in  1  1=zero-extend load, 0=sign-extend
- io_stall  out  1  hold EX/MEM register and upstream stages
- io_resp_valid  out  1  io_resp_data valid / store completed this cycle
- io_resp_data  out  32  extended load result
- io_misaligned  out  1  misaligned exception (EXC_ON_MISALIGN=1 only)
- io_cache_addr  out  32  to DataCache io_addr
- io_cache_write_data  out  32  to DataCache io_write_data
- io_cache_Mem_Read  out  1  to DataCache io_Mem_Read
- io_cache_Mem_Write  out  1  to DataCache io_Mem_Write
- io_cache_Data_Size  out  2  to DataCache io_Data_Size
- io_cache_Load_Type  out  1  to DataCache io_Load_Type
- io_cache_data_out  in  32  from DataCache io_data_out

Behaviour:
- DataCache contract: combinational read (io_data_out valid in the same cycle as the address); write commits on the rising clock edge.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. A byte access is never misaligned.
- Read and write both set: treated as write only.
- Reset (reset=0, asynchronous):
  - state=IDLE, byte counter=0, lo_word register=0.
  - io_stall, io_resp_valid, io_misaligned, io_cache_Mem_Read and io_cache_Mem_Write are all 0.
  - io_resp_data=0 and io_cache_addr=0.
- Reset during a split operation aborts it. Bytes already written stay in memory and no response is produced.
- IDLE, aligned request:
  - Drive the cache combinationally from the req_* inputs: Load_Type=req_unsigned, Data_Size=req_size.
  - Set io_resp_valid=1 and io_resp_data=io_cache_data_out. Stall=0.
- IDLE, misaligned load:
  - Drive cache addr = addr & ~3, Data_Size=2, Mem_Read=1. Capture data_out into lo_word.
  - Set io_stall=1 and move to LD_HI.
- LD_HI:
  - Drive cache addr = (addr & ~3) + 4, modulo 2^32 (0xFFFFFFFC wraps to 0), Data_Size=2, Mem_Read=1.
  - Form the 64-bit value {data_out, lo_word} and shift it right by 8*addr[1:0].
  - Take the low 8*bytes bits and extend them per req_unsigned.
  - io_resp_valid=1, io_stall=0, return to IDLE. Latency is 2 cycles.
- IDLE, misaligned store with N bytes (2 or 4):
  - Move to ST_BYTE with counter k=0 in the first cycle; the first byte write also happens in this cycle.
  - Each cycle: cache addr = addr + k (mod 2^32), Data_Size=0, Mem_Write=1, write_data = byte k of wdata in bits [7:0].
  - io_stall=1 while k<N-1.
  - When k=N-1: io_stall=0, io_resp_valid=1, return to IDLE. Latency is N cycles.
- The upstream stage holds all req_* inputs stable while io_stall=1.
- io_req_valid dropping to 0 in LD_HI or ST_BYTE (flush) aborts to IDLE on the next edge. Outputs that cycle: no response, no cache access, stall=0.
- io_req_valid=0 in IDLE: cache enables 0, resp_valid 0, stall 0.
- EXC_ON_MISALIGN=1: io_misaligned = valid & misaligned, combinational, for one cycle. Cache enables 0, no state change.

Test Plan:
- Preload mem[0x100]=0x44332211, mem[0x104]=0x88776695. Aligned word load at 0x100 -> same-cycle resp_valid=1, resp_data=0x44332211, stall never 1.
- Word load at 0x102 -> stall=1 for one cycle, cache addresses 0x100 then 0x104, resp_data=0x66954433 in cycle 2.
- Signed half load at 0x103 -> resp_data=0xFFFF9544. The same access with io_req_unsigned=1 -> 0x00009544.
- Word store 0xDEADBEEF at 0x0FE:
  - Byte writes EF@0xFE, BE@0xFF, AD@0x100, DE@0x101; stall pattern 1,1,1,0.
  - Subsequent aligned load at 0x100 -> 0x4433DEAD.
- Word load at 0xFFFFFFFE -> second cache address is 0x00000000. Asserting reset in LD_HI -> stall/resp_valid=0 immediately, state IDLE.
- EXC_ON_MISALIGN=1, half load at 0x101 -> io_misaligned=1 for one cycle, Mem_Read=0, stall=0.
